ppu_frame_writer: RTL



---
 rtl/ppu_frame_writer_if.sv | 23 ++
 rtl/ppu_frame_writer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ppu_frame_writer_if.sv
// Pixel stream from the PPU and frame buffer write port of ppu_frame_writer.
// The master side is the PPU/BRAM environment; the writer is the slave.
interface ppu_frame_writer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [1:0]        pixel_in;
    logic              pixel_valid_in;
    logic              hblank_in;
    logic              vblank_in;
    logic [ADDR_W-1:0] fb_addr_out;
    logic [1:0]        fb_data_out;
    logic              fb_we_out;

    modport master (
        output pixel_in, pixel_valid_in, hblank_in, vblank_in,
        input  fb_addr_out, fb_data_out, fb_we_out
    );

    modport slave (
        input  pixel_in, pixel_valid_in, hblank_in, vblank_in,
        output fb_addr_out, fb_data_out, fb_we_out
    );
endinterface

// File: rtl/ppu_frame_writer.sv
// Writes the PPU shade stream into a raster-addressed frame buffer and flags raster errors.
// Define FRAME_WRITER_DOUBLE_BUF_EN for two ping-pong banks; otherwise a single bank is used.
module ppu_frame_writer #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 144,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    ppu_frame_writer_if.slave    bus,
    output logic                 disp_bank_out,
    output logic                 frame_done_out,
    output logic                 err_out,
    output logic [7:0]           x_out,
    output logic [7:0]           y_out
);
    localparam int unsigned      FRAME_PIX  = WIDTH * HEIGHT;
    localparam logic [7:0]       X_LAST     = 8'(WIDTH - 1);
    localparam logic [7:0]       Y_END      = 8'(HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_PIX);
    localparam logic             DISP_RST   = 1'b1;
`else
    localparam logic [ADDR_W-1:0] BANK1_BASE = '0;
    localparam logic             DISP_RST   = 1'b0;
`endif

    typedef enum logic [1:0] {SYNC, ACTIVE, LINE_WAIT, FRAME_WAIT} state_t;

    state_t            state_q, state_d;
    logic              hblank_q, vblank_q;
    logic [7:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d;
    logic              bank_q, bank_d, disp_bank_q, disp_bank_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [1:0]        fb_data_q, fb_data_d;
    logic              fb_we_q, fb_we_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;
    logic              hb_rise, vb_rise, vb_fall;

    assign hb_rise = bus.hblank_in & ~hblank_q;
    assign vb_rise = bus.vblank_in & ~vblank_q;
    assign vb_fall = ~bus.vblank_in & vblank_q;

    function automatic logic [ADDR_W-1:0] bank_base(input logic b);
        return b ? BANK1_BASE : '0;
    endfunction

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= SYNC;
            hblank_q     <= 1'b0;
            vblank_q     <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            line_base_q  <= '0;
            bank_q       <= 1'b0;
            disp_bank_q  <= DISP_RST;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hblank_q     <= bus.hblank_in;
            vblank_q     <= bus.vblank_in;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            line_base_q  <= line_base_d;
            bank_q       <= bank_d;
            disp_bank_q  <= disp_bank_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Next state: pixel first, then hblank edge on the updated position, then vblank edge
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        line_base_d  = line_base_q;
        bank_d       = bank_q;
        disp_bank_d  = disp_bank_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_we_d      = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;

        case (state_q)
            SYNC: begin
                if (vb_fall) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (bus.pixel_valid_in) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = addr_q;
                    fb_data_d = bus.pixel_in;
                    addr_d    = addr_q + ADDR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d         = '0;
                        line_base_d = addr_q + ADDR_W'(1);
                        state_d     = LINE_WAIT;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            LINE_WAIT: begin
                if (bus.pixel_valid_in) err_d = 1'b1;
            end
            default: ;
        endcase

        if (hb_rise) begin
            if (state_d == LINE_WAIT) begin
                y_d     = y_q + 8'd1;
                state_d = ((y_q + 8'd1) == Y_END) ? FRAME_WAIT : ACTIVE;
            end else if (state_d == ACTIVE && x_d != 8'd0) begin
                // Short line: abandon the rest of it and jump to the next line start
                err_d       = 1'b1;
                x_d         = '0;
                line_base_d = line_base_q + LINE_STEP;
                addr_d      = line_base_q + LINE_STEP;
                y_d         = y_q + 8'd1;
                state_d     = ((y_q + 8'd1) == Y_END) ? FRAME_WAIT : ACTIVE;
            end
        end

        if (vb_rise) begin
            if (state_d == FRAME_WAIT) begin
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
                bank_d      = ~bank_q;
                disp_bank_d = bank_q;
`endif
                frame_done_d = 1'b1;
                x_d          = '0;
                y_d          = '0;
                addr_d       = bank_base(bank_d);
                line_base_d  = bank_base(bank_d);
                state_d      = SYNC;
            end else if (state_d == ACTIVE || state_d == LINE_WAIT) begin
                err_d       = 1'b1;
                x_d         = '0;
                y_d         = '0;
                addr_d      = bank_base(bank_q);
                line_base_d = bank_base(bank_q);
                state_d     = SYNC;
            end
        end
    end

    assign bus.fb_addr_out = fb_addr_q;
    assign bus.fb_data_out = fb_data_q;
    assign bus.fb_we_out   = fb_we_q;
    assign disp_bank_out   = disp_bank_q;
    assign frame_done_out  = frame_done_q;
    assign err_out         = err_q;
    assign x_out           = x_q;
    assign y_out           = y_q;
endmodule
